// File: rtl/aes_kat_sequencer.sv
// AES known-answer self-test sequencer.
// Runs the six FIPS-197 App. C vectors (enc/dec x 128/192/256) through one shared
// AES engine over a start/done handshake and latches one pass flag per vector.
// Optional build macro: AES_KAT_LOOP_EN -- when defined, holding go high at the
// end of a pass restarts the sequence immediately (continuous BIST).
module aes_kat_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    output logic         eng_start,
    output logic         eng_decrypt,
    output logic [1:0]   eng_keysize,
    output logic [255:0] eng_key,
    output logic [127:0] eng_din,
    input  logic         eng_done,
    input  logic [127:0] eng_dout,
    output logic         busy,
    output logic         done,
    output logic [5:0]   pass_vec,
    output logic         all_pass,
    output logic         timeout_err
);

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state, next_state;
    logic [2:0]      idx, next_idx;
    logic [TO_W-1:0] to_cnt;
    logic [127:0]    result;
    logic            timed_out;
    logic            load;       // entering ISSUE: reload engine controls for next_idx
    logic            clr;        // fresh run from IDLE/DONE: clear flags
    logic            wrap;       // continuous-mode restart at the end of a pass
    logic            loop_pulse;

    // Key size follows the vector index modulo 3 (0..2 enc, 3..5 dec).
    function automatic logic [1:0] ks_of(input logic [2:0] i);
        logic [2:0] t;
        t = (i >= 3'd3) ? i - 3'd3 : i;
        return t[1:0];
    endfunction

    function automatic logic [127:0] cipher_of(input logic [1:0] ks);
        case (ks)
            2'd0:    return C128;
            2'd1:    return C192;
            default: return C256;
        endcase
    endfunction

    // Keys are left-justified in the 256-bit bus with zero fill below.
    function automatic logic [255:0] key_of(input logic [1:0] ks);
        case (ks)
            2'd0:    return {K128, 128'h0};
            2'd1:    return {K192, 64'h0};
            default: return K256;
        endcase
    endfunction

    // Next-state, index sequencing and load/clear strobes.
    always_comb begin
        next_state = state;
        next_idx   = idx;
        load       = 1'b0;
        clr        = 1'b0;
        wrap       = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (go) begin
                    next_state = S_ISSUE;
                    next_idx   = 3'd0;
                    load       = 1'b1;
                    clr        = 1'b1;
                end
            end
            S_ISSUE: next_state = S_WAIT;
            S_WAIT: begin
                // A done arriving on the last allowed cycle still counts.
                if (eng_done || to_cnt == TO_LIM) next_state = S_CHECK;
            end
            S_CHECK: begin
                if (idx == 3'd5) begin
`ifdef AES_KAT_LOOP_EN
                    if (go) begin
                        next_state = S_ISSUE;
                        next_idx   = 3'd0;
                        load       = 1'b1;
                        wrap       = 1'b1;
                    end else begin
                        next_state = S_DONE;
                    end
`else
                    next_state = S_DONE;
`endif
                end else begin
                    next_state = S_ISSUE;
                    next_idx   = idx + 3'd1;
                    load       = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State, engine controls, timeout tracking and per-vector result flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= 3'd0;
            to_cnt      <= '0;
            result      <= '0;
            timed_out   <= 1'b0;
            loop_pulse  <= 1'b0;
            eng_decrypt <= 1'b0;
            eng_keysize <= 2'd0;
            eng_key     <= '0;
            eng_din     <= '0;
            pass_vec    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state      <= next_state;
            idx        <= next_idx;
            loop_pulse <= wrap;
            if (load) begin
                eng_decrypt <= (next_idx >= 3'd3);
                eng_keysize <= ks_of(next_idx);
                eng_key     <= key_of(ks_of(next_idx));
                eng_din     <= (next_idx >= 3'd3) ? cipher_of(ks_of(next_idx)) : PT;
            end
            if (clr) begin
                pass_vec    <= '0;
                timeout_err <= 1'b0;
            end
            case (state)
                S_ISSUE: begin
                    to_cnt    <= '0;
                    timed_out <= 1'b0;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        result <= eng_dout;
                    end else if (to_cnt == TO_LIM) begin
                        timed_out   <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    pass_vec[idx] <= (result == ((idx >= 3'd3) ? PT : cipher_of(ks_of(idx))))
                                     & ~timed_out;
                end
                default: ;
            endcase
        end
    end

    assign eng_start = (state == S_ISSUE);
    assign busy      = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CHECK);
    assign done      = (state == S_DONE) || loop_pulse;
    assign all_pass  = done & (&pass_vec);

endmodule
